// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and access-size constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_EXT = 1'b1
    } arbState_t;

    // DM_Sel access-size encoding used by the MEM stage and the EXT port
    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// rtl/dmem_arb_starve_cnt.sv - counts consecutive cycles the EXT port has been blocked by CPU traffic
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             atMax
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_WAIT);

    // Saturates at MAX_VAL so a held increment can never wrap back to zero
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !atMax) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign atMax = (cnt == MAX_VAL);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares DataMemory between the MEM stage and an EXT loader port
// Optional ARB_PERF_CNT_EN adds perf_stall_cycles / perf_ext_grants counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_sel,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [1:0]        ext_sel,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [1:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_ext_grants
`endif
);

    arbState_t        state;
    arbState_t        nextState;
    logic             cpuReq;
    logic             cntClr;
    logic             cntInc;
    logic             atMax;
    logic [CNT_W-1:0] waitCnt;

    assign cpuReq = cpu_re | cpu_we;

    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_starve_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr   (cntClr),
        .inc   (cntInc),
        .cnt   (waitCnt),
        .atMax (atMax)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_CPU;
        end else begin
            state <= nextState;
        end
    end

    // All outputs stay at zero while Rst is low, so an in-flight EXT write is dropped at once
    always_comb begin
        nextState = state;
        cntClr    = 1'b0;
        cntInc    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_sel   = '0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        if (Rst) begin
            case (state)
                S_CPU: begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    mem_we    = cpu_we;
                    mem_re    = cpu_re;
                    mem_sel   = cpu_sel;
                    cpu_rdata = mem_rdata;
                    if (ext_req) begin
                        if (!cpuReq || atMax) begin
                            nextState = S_EXT;
                            cntClr    = 1'b1;
                        end else begin
                            cntInc = 1'b1;
                        end
                    end else begin
                        cntClr = 1'b1;
                    end
                end
                S_EXT: begin
                    mem_addr  = ext_addr;
                    mem_wdata = ext_wdata;
                    mem_we    = ext_we;
                    mem_re    = !ext_we;
                    mem_sel   = ext_sel;
                    ext_ack   = 1'b1;
                    ext_rdata = mem_rdata;
                    cpu_stall = cpuReq;
                    nextState = S_CPU;
                    cntClr    = 1'b1;
                end
                default: begin
                    nextState = S_CPU;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            perf_stall_cycles <= '0;
            perf_ext_grants   <= '0;
        end else begin
            if (cpu_stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (state == S_EXT) begin
                perf_ext_grants <= perf_ext_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for the data-memory port arbiter
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [1:0]  cpu_sel = SEL_WORD;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ext_req = 1'b0;
    logic        ext_we = 1'b0;
    logic [11:0] ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic [1:0]  ext_sel = SEL_WORD;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_sel;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_ext_grants;
`endif

    always #5 Clk = ~Clk;

    dmem_port_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .MAX_WAIT (4),
        .CNT_W    (3)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_sel   (cpu_sel),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_sel   (ext_sel),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_ext_grants   (perf_ext_grants)
`endif
    );

    // Word-organised DataMemory model with combinational read
    logic [31:0] dmem [0:1023];
    assign mem_rdata = dmem[mem_addr[11:2]];
    always @(posedge Clk) begin
        if (mem_we) dmem[mem_addr[11:2]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        stall;
        int          cyc;
    } extExp_t;

    extExp_t     expQ[$];
    extExp_t     e;
    int          checks = 0;
    int          failures = 0;
    logic        cpuChkEn = 1'b0;
    logic [31:0] cpuExpData = '0;
    int          stallSeen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // EXT-side monitor: every ack must match the oldest pending expectation
    always @(negedge Clk) begin
        if (Rst && ext_ack) begin
            if (expQ.size() == 0) begin
                chk("ext_ack_unexpected", 64'(ext_ack), 64'd0);
            end else begin
                e = expQ.pop_front();
                chk("ext_ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("ext_mem_addr", 64'(mem_addr), 64'(e.addr));
                chk("ext_mem_we", 64'(mem_we), 64'(e.we));
                chk("ext_mem_re", 64'(mem_re), 64'(!e.we));
                chk("ext_cpu_stall", 64'(cpu_stall), 64'(e.stall));
                chk("cpu_rdata_during_ext", 64'(cpu_rdata), 64'd0);
                if (e.we) chk("ext_mem_wdata", 64'(mem_wdata), 64'(e.data));
                else      chk("ext_rdata", 64'(ext_rdata), 64'(e.data));
            end
        end
    end

    // CPU-side monitor for load windows
    always @(negedge Clk) begin
        if (Rst && cpuChkEn && cpu_re) begin
            if (cpu_stall) begin
                stallSeen++;
                chk("cpu_rdata_stalled", 64'(cpu_rdata), 64'd0);
            end else begin
                chk("cpu_rdata", 64'(cpu_rdata), 64'(cpuExpData));
                chk("cpu_mem_addr", 64'(mem_addr), 64'(cpu_addr));
            end
        end
    end

    // Called just after a rising edge; ack is expected 'delay' cycles after issue
    task automatic extAccess(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                             input logic [31:0] expData, input logic expStall, input int delay,
                             input bit hold);
        extExp_t x;
        bit      got;
        ext_req   = 1'b1;
        ext_we    = we;
        ext_addr  = addr;
        ext_wdata = wdata;
        ext_sel   = SEL_WORD;
        x.we    = we;
        x.addr  = addr;
        x.data  = we ? wdata : expData;
        x.stall = expStall;
        x.cyc   = cyc + delay;
        expQ.push_back(x);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            if (ext_ack) got = 1'b1;
        end
        if (!got) begin
            chk("ext_ack_timeout", 64'(ext_ack), 64'd1);
            void'(expQ.pop_back());
        end
        @(posedge Clk);
        #1;
        if (!hold) ext_req = 1'b0;
    endtask

    // Continuous loads with EXT read held: five CPU cycles, then one stalled EXT cycle
    task automatic runScen2();
        cpuExpData = 32'hDEADBEEF;
        stallSeen  = 0;
        cpuChkEn   = 1'b1;
        cpu_re     = 1'b1;
        cpu_addr   = 12'h010;
        extAccess(1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b1, 5, 1'b0);
        @(negedge Clk);
        @(posedge Clk);
        #1;
        cpu_re   = 1'b0;
        cpuChkEn = 1'b0;
        chk("stall_cycles_per_grant", 64'(stallSeen), 64'd1);
    endtask

    initial begin
`ifdef ARB_PERF_CNT_EN
        logic [31:0] ps0;
        logic [31:0] pg0;
`endif
        // Reset: memory strobes and all outputs held low even with requests present
        cpu_re   = 1'b1;
        cpu_addr = 12'h010;
        ext_req  = 1'b1;
        ext_we   = 1'b1;
        ext_addr = 12'h044;
        #2;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ext_ack", 64'(ext_ack), 64'd0);
        chk("rst_ext_rdata", 64'(ext_rdata), 64'd0);
        cpu_re  = 1'b0;
        ext_req = 1'b0;
        ext_we  = 1'b0;
        Rst     = 1'b1;
        @(posedge Clk);
        #1;

        // Idle CPU: EXT write granted the next cycle without stalling
        extAccess(1'b1, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b0);
        chk("mem_after_ext_write", 64'(dmem[4]), 64'h0000_0000_DEAD_BEEF);

        // Forced grant after MAX_WAIT blocked cycles
        runScen2();

        // Write then read with ext_req held across acks
        extAccess(1'b1, 12'h020, 32'h12345678, 32'h0, 1'b0, 1, 1'b1);
        extAccess(1'b0, 12'h020, 32'h0, 32'h12345678, 1'b0, 1, 1'b0);

        // Same-cycle CPU store and EXT read: CPU goes first, EXT sees the stored word
        cpu_we    = 1'b1;
        cpu_addr  = 12'h030;
        cpu_wdata = 32'hCAFEF00D;
        fork
            extAccess(1'b0, 12'h030, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0);
            begin
                @(posedge Clk);
                #1;
                cpu_we = 1'b0;
            end
        join

        // Reset in the middle of an EXT write
        extAccess(1'b1, 12'h040, 32'h11111111, 32'h0, 1'b0, 1, 1'b0);
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 12'h040;
        ext_wdata = 32'h55AA55AA;
        @(posedge Clk);
        #1;
        chk("pre_abort_mem_we", 64'(mem_we), 64'd1);
        Rst = 1'b0;
        #1;
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_ext_ack", 64'(ext_ack), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        ext_req = 1'b0;
        ext_we  = 1'b0;
        Rst     = 1'b1;
        chk("abort_mem_unchanged", 64'(dmem[16]), 64'h0000_0000_1111_1111);
        @(posedge Clk);
        #1;
        runScen2();

`ifdef ARB_PERF_CNT_EN
        ps0 = perf_stall_cycles;
        pg0 = perf_ext_grants;
        repeat (3) runScen2();
        chk("perf_ext_grants_delta", 64'(perf_ext_grants - pg0), 64'd3);
        chk("perf_stall_cycles_delta", 64'(perf_stall_cycles - ps0), 64'd3);
`endif

        repeat (2) @(posedge Clk);
        chk("exp_queue_empty", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port). The CPU owns the memory by default with zero added latency. EXT is served in idle MEM cycles, or forcibly after a bounded wait, during which the arbiter stalls the pipeline. Sits between EX_MEM outputs / DataMemory inputs and feeds the existing stall network.

Parameters:
ADDR_W, 12, memory byte-address width (matches ALUResult_MEM[11:0])
DATA_W, 32, data width
MAX_WAIT, 4, max consecutive cycles EXT may be blocked by CPU traffic before a forced grant; 0 = EXT wins on the next cycle
CNT_W, 3, wait-counter width; must hold MAX_WAIT

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
cpu_re  in  1  MEM-stage read request
cpu_we  in  1  MEM-stage write request
cpu_addr  in  ADDR_W  MEM-stage address
cpu_wdata  in  DATA_W  MEM-stage store data
cpu_sel  in  2  access size (DM_Sel encoding)
cpu_rdata  out  DATA_W  read data to MEM stage
cpu_stall  out  1  hold PC, IF_ID, ID_EX, EX_MEM; bubble MEM_WB
ext_req  in  1  EXT access request; level, held until ext_ack
ext_we  in  1  1 = write, 0 = read
ext_addr  in  ADDR_W  EXT address
ext_wdata  in  DATA_W  EXT store data
ext_sel  in  2  EXT access size
ext_ack  out  1  access completes at this rising edge
ext_rdata  out  DATA_W  EXT read data, valid while ext_ack
mem_addr, mem_wdata, mem_we, mem_re, mem_sel  out  ADDR_W/DATA_W/1/1/2  to DataMemory
mem_rdata  in  DATA_W  DataMemory combinational read data

Behaviour:
- States: S_CPU (reset), S_EXT. Registers: state, wait_cnt[CNT_W-1:0].
- cpu_req = cpu_re | cpu_we.
- S_CPU: mem_* = cpu_*; cpu_rdata = mem_rdata; cpu_stall = 0; ext_ack = 0.
  - ext_req & !cpu_req -> S_EXT, wait_cnt <= 0.
  - ext_req & cpu_req & wait_cnt == MAX_WAIT -> S_EXT, wait_cnt <= 0. The CPU access in this cycle still completes.
  - ext_req & cpu_req & wait_cnt < MAX_WAIT -> stay, wait_cnt++.
  - !ext_req -> stay, wait_cnt <= 0.
- S_EXT, exactly one cycle:
  - mem_* = ext_*; mem_re = !ext_we; ext_ack = 1; ext_rdata = mem_rdata.
  - cpu_stall = cpu_req; cpu_rdata = 0.
  - Always -> S_CPU.
- Back-to-back EXT: after S_EXT the arbiter spends at least one cycle in S_CPU. EXT bandwidth is therefore at most 1/2 when CPU is idle, and 1/(MAX_WAIT+2) under continuous CPU traffic.
- The EXT requester samples ext_ack at the edge and must deassert ext_req or present a new request.
- ext_* is ignored unless ext_req = 1. The arbiter does not check stability; the EXT requester must hold fields stable while requesting.
- Simultaneous first-cycle requests: CPU wins unless MAX_WAIT = 0 and wait_cnt = 0. In that case EXT goes next cycle.
- Reset (Rst low, async):
  - state = S_CPU, wait_cnt = 0.
  - mem_we = mem_re = 0 forced combinationally while Rst is low.
  - cpu_stall = 0, ext_ack = 0, ext_rdata = 0, cpu_rdata = 0.
  - Reset mid-S_EXT aborts the access with no ack and no write.
- Outputs other than mem_we/mem_re while in reset: 0.

Optional Feature:
ARB_PERF_CNT_EN: adds outputs perf_stall_cycles[31:0] and perf_ext_grants[31:0].
- perf_stall_cycles increments each cycle cpu_stall = 1; perf_ext_grants increments each S_EXT cycle.
- Both wrap at 2^32 and clear on reset.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding S_CPU = 1'b0, S_EXT = 1'b1;
  - DM_Sel constants SEL_WORD = 2'b00, SEL_HALF = 2'b01, SEL_BYTE = 2'b10.
- Sub-module dmem_arb_starve_cnt: wait counter with clear/inc/at_max. Parameterised on MAX_WAIT and CNT_W.

Test Plan:
1. Idle CPU, ext_req write addr 0x010, data 0xDEADBEEF, SEL_WORD -> S_EXT the next cycle; ext_ack for 1 cycle; mem_we = 1, mem_addr = 0x010; cpu_stall stays 0.
2. CPU continuous loads, ext_req held, MAX_WAIT = 4 -> 5 CPU cycles served. Next cycle S_EXT with cpu_stall = 1 and ext_ack = 1. cpu_addr is held by the stalled pipeline and served the cycle after.
3. EXT read 0x020 after write 0x12345678 -> ext_rdata = 0x12345678 while ext_ack. ext_req kept high -> next ack no sooner than 2 cycles later.
4. Simultaneous cpu_we and ext_req in a fresh cycle -> CPU write is issued first; EXT acked only after CPU is idle or the wait expires.
5. Rst asserted low during S_EXT write -> mem_we falls immediately, no ack, memory unchanged. After release, state = S_CPU and wait_cnt = 0.
6. ARB_PERF_CNT_EN build, scenario 2 run 3 times -> perf_ext_grants = 3, perf_stall_cycles = 3.
